// File: rtl/mips_pkg.sv
// Shared datapath definitions: register address/data widths and the
// write-back queue entry layout.
package mips_pkg;

    localparam int ADDR_W = 6;
    localparam int DATA_W = 32;

    // One pending register-file write: destination register and value
    typedef struct packed {
        logic [ADDR_W-1:0] destino;
        logic [DATA_W-1:0] dado;
    } entrada_escrita_t;

endpackage

// File: rtl/busca_pendente.sv
// Youngest-match search over the occupied slots of the write-back queue.
// Returns the data of the most recently queued entry whose destination
// equals the requested address.
module busca_pendente
    import mips_pkg::*;
#(
    parameter int DEPTH = 4,
    parameter int PTR_W = $clog2(DEPTH)
) (
    input  entrada_escrita_t  i_fila [DEPTH],
    input  logic [PTR_W-1:0]  i_cabeca,
    input  logic [PTR_W:0]    i_contagem,
    input  logic [ADDR_W-1:0] i_endereco,
    output logic              o_acerto,
    output logic [DATA_W-1:0] o_dado
);

    // Scan oldest to youngest so the last match kept is the youngest one
    always_comb begin
        o_acerto = 1'b0;
        o_dado   = '0;
        for (int unsigned i = 0; i < DEPTH; i++) begin
            if (((PTR_W+1)'(i) < i_contagem) &&
                (i_fila[PTR_W'(i_cabeca + PTR_W'(i))].destino == i_endereco)) begin
                o_acerto = 1'b1;
                o_dado   = i_fila[PTR_W'(i_cabeca + PTR_W'(i))].dado;
            end
        end
    end

endmodule

// File: rtl/fila_escrita.sv
// Write-back queue in front of the register file. Buffers ALU and memory
// results in a circular FIFO and commits one entry per cycle.
// Optional pending-write lookup for bypassing: define FILA_ESCRITA_FWD_EN.
module fila_escrita #(
    parameter int DEPTH  = 4,
    parameter int ADDR_W = mips_pkg::ADDR_W,
    parameter int DATA_W = mips_pkg::DATA_W
) (
    input  logic                       clock,
    input  logic                       reset,
    input  logic                       mem_valido,
    input  logic [ADDR_W-1:0]          mem_reg,
    input  logic [DATA_W-1:0]          mem_dado,
    output logic                       mem_pronto,
    input  logic                       ula_valido,
    input  logic [ADDR_W-1:0]          ula_reg,
    input  logic [DATA_W-1:0]          ula_dado,
    output logic                       ula_pronto,
    output logic                       reg_write,
    output logic [ADDR_W-1:0]          reg_escrita,
    output logic [DATA_W-1:0]          escreve_dado,
    output logic                       vazia,
    output logic                       cheia,
    output logic [$clog2(DEPTH):0]     contagem
`ifdef FILA_ESCRITA_FWD_EN
    ,
    input  logic [ADDR_W-1:0]          fwd_reg1,
    input  logic [ADDR_W-1:0]          fwd_reg2,
    output logic                       fwd_hit1,
    output logic                       fwd_hit2,
    output logic [DATA_W-1:0]          fwd_dado1,
    output logic [DATA_W-1:0]          fwd_dado2
`endif
);

    import mips_pkg::*;

    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = PTR_W + 1;

    entrada_escrita_t   r_fila [DEPTH];
    logic [PTR_W-1:0]   r_cabeca;
    logic [PTR_W-1:0]   r_cauda;
    logic [CNT_W-1:0]   r_contagem;

    logic               w_vazia;
    logic [CNT_W-1:0]   w_livre;
    logic               w_mem_push;
    logic               w_ula_push;
    logic               w_pop;
    logic [PTR_W-1:0]   w_idx_ula;

    assign w_vazia = (r_contagem == '0);
    assign w_pop   = !w_vazia;

    // The head always drains this cycle, so its slot counts as free
    assign w_livre = CNT_W'(DEPTH) - r_contagem + CNT_W'(w_pop);

    assign mem_pronto = (w_livre >= CNT_W'(1));
    assign w_mem_push = mem_valido && mem_pronto;
    assign ula_pronto = (w_livre >= (CNT_W'(1) + CNT_W'(w_mem_push)));
    assign w_ula_push = ula_valido && ula_pronto;

    // Memory result is older: it takes the tail slot, ALU goes right after
    assign w_idx_ula = w_mem_push ? PTR_W'(r_cauda + PTR_W'(1)) : r_cauda;

    // Pointer and occupancy bookkeeping
    always_ff @(posedge clock) begin
        if (reset) begin
            r_cabeca   <= '0;
            r_cauda    <= '0;
            r_contagem <= '0;
        end else begin
            r_cabeca   <= r_cabeca + PTR_W'(w_pop);
            r_cauda    <= r_cauda + PTR_W'(w_mem_push) + PTR_W'(w_ula_push);
            r_contagem <= r_contagem + CNT_W'(w_mem_push) + CNT_W'(w_ula_push)
                          - CNT_W'(w_pop);
        end
    end

    // Entry storage; contents are only meaningful inside the occupied window
    always_ff @(posedge clock) begin
        if (!reset) begin
            if (w_mem_push) begin
                r_fila[r_cauda] <= '{destino: mem_reg, dado: mem_dado};
            end
            if (w_ula_push) begin
                r_fila[w_idx_ula] <= '{destino: ula_reg, dado: ula_dado};
            end
        end
    end

    assign reg_write    = !w_vazia;
    assign reg_escrita  = w_vazia ? '0 : r_fila[r_cabeca].destino;
    assign escreve_dado = w_vazia ? '0 : r_fila[r_cabeca].dado;
    assign vazia        = w_vazia;
    assign cheia        = (r_contagem == CNT_W'(DEPTH));
    assign contagem     = r_contagem;

`ifdef FILA_ESCRITA_FWD_EN
    logic              w_acerto1;
    logic              w_acerto2;
    logic [DATA_W-1:0] w_dado1;
    logic [DATA_W-1:0] w_dado2;

    busca_pendente #(.DEPTH(DEPTH)) u_busca1 (
        .i_fila     (r_fila),
        .i_cabeca   (r_cabeca),
        .i_contagem (r_contagem),
        .i_endereco (fwd_reg1),
        .o_acerto   (w_acerto1),
        .o_dado     (w_dado1)
    );

    busca_pendente #(.DEPTH(DEPTH)) u_busca2 (
        .i_fila     (r_fila),
        .i_cabeca   (r_cabeca),
        .i_contagem (r_contagem),
        .i_endereco (fwd_reg2),
        .o_acerto   (w_acerto2),
        .o_dado     (w_dado2)
    );

    // Entries about to be discarded by reset must not be forwarded
    assign fwd_hit1  = w_acerto1 && !reset;
    assign fwd_hit2  = w_acerto2 && !reset;
    assign fwd_dado1 = reset ? '0 : w_dado1;
    assign fwd_dado2 = reset ? '0 : w_dado2;
`endif

endmodule
